// File: rtl/trp_ctrl.sv
// trp_ctrl: round-robin scheduler feeding one shared transpose/reduction unit.
// Optional WAIT watchdog enabled by defining TRP_CTRL_TIMEOUT_EN.
module trp_ctrl #(
    parameter int WIDTH          = 32,
    parameter int NUM_ELEMS      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req,
    input  logic [1:0]       req_mode0,
    input  logic [1:0]       req_mode1,
    output logic [1:0]       gnt,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             trp_en,
    output logic [WIDTH-1:0] trp_a,
    output logic [1:0]       trp_mode,
    input  logic             trp_busy,
    input  logic             trp_valid,
    input  logic [WIDTH-1:0] trp_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_err
);

    localparam int CW = $clog2(NUM_ELEMS + 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [1:0]       mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rid_q, rid_d;
    logic             pick;

`ifdef TRP_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic          expired;
    assign expired = (tcnt_q == TW'(TIMEOUT_CYCLES));
`endif

    // On a tie the requester not served last wins
    assign pick = (req == 2'b11) ? ~last_q : req[1];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        a_d     = a_q;
        rv_d    = rv_q;
        rd_d    = rd_q;
        rid_d   = rid_q;
`ifdef TRP_CTRL_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if ((|req) && !trp_busy) begin
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    mode_d  = pick ? req_mode1 : req_mode0;
                    cnt_d   = '0;
                    state_d = FEED;
                end
            end
            FEED: begin
                if (in_valid) begin
                    en_d  = 1'b1;
                    a_d   = in_data;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(NUM_ELEMS - 1)) begin
                        state_d = WAIT;
`ifdef TRP_CTRL_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (trp_valid) begin
                    rv_d    = 1'b1;
                    rd_d    = trp_out;
                    rid_d   = gnt_q[1];
`ifdef TRP_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = HOLD;
`ifdef TRP_CTRL_TIMEOUT_EN
                end else if (expired) begin
                    rv_d    = 1'b1;
                    rd_d    = '0;
                    rid_d   = gnt_q[1];
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
`endif
                end
            end
            HOLD: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            a_q     <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            a_q     <= a_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            rid_q   <= rid_d;
        end
    end

`ifdef TRP_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign in_ready  = (state_q == FEED);
    assign trp_en    = en_q;
    assign trp_a     = a_q;
    assign trp_mode  = mode_q;
    assign res_valid = rv_q;
    assign res_data  = rd_q;
    assign res_id    = rid_q;

endmodule

// File: doc/trp_ctrl.md
# trp_ctrl

Scheduler that shares one transpose/reduction unit between two requesters. It round-robin arbitrates, latches the winner's reduction mode and streams exactly NUM_ELEMS operand beats into the unit. It then waits for the unit's result and returns it with the requester's ID through a valid/ready result port. It sits between the vector lanes' reduction issue logic and the trp unit's en/mode/a/valid/out pins.

## Interface
- WIDTH, 32, element/result width in bits
- NUM_ELEMS, 8, operand beats per operation (>=1)
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT (used only with TRP_CTRL_TIMEOUT_EN)

- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  2  per-requester operation request, level, held until granted
- req_mode0 / req_mode1  in  2 each  reduction type of requester 0 / 1
- gnt  out  2  one-hot grant, high from grant until result handshake completes
- in_valid  in  1  operand beat valid from granted requester
- in_data  in  WIDTH  operand beat
- in_ready  out  1  controller accepts beat (high only in FEED)
- trp_en  out  1  operand strobe to unit, registered
- trp_a  out  WIDTH  operand to unit, registered
- trp_mode  out  2  latched mode, stable for whole operation
- trp_busy  in  1  unit busy
- trp_valid  in  1  unit result valid
- trp_out  in  WIDTH  unit result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  captured result
- res_id  out  1  requester index owning res_data
- res_err  out  1  result produced by watchdog timeout (0 without macro)

## Operation
- FSM states: IDLE, FEED, WAIT, HOLD; reset state IDLE.
- IDLE: when any req bit is high and trp_busy=0, grant. If both are high, grant the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie. Latch trp_mode from the winner's req_mode, clear beat counter, go FEED.
- IDLE with trp_busy=1: no grant. Requests wait.
- FEED: in_ready=1. Each cycle with in_valid=1 is an accepted beat. Next cycle trp_en=1 and trp_a=in_data; otherwise trp_en=0 and trp_a holds its value. The counter is WIDTH-independent, $clog2(NUM_ELEMS+1) bits. On acceptance of beat NUM_ELEMS, go WAIT and drop in_ready the next cycle.
- WAIT: on trp_valid=1, capture trp_out into res_data, set res_id = granted index and res_err=0, go HOLD. trp_valid outside WAIT is ignored.
- HOLD: res_valid=1, data stable. On res_valid&res_ready, clear res_valid and gnt, update the last-grant pointer, go IDLE. A new grant is possible on the following cycle at the earliest.
- req deasserting after grant does not abort the operation.
- Async reset mid-operation: all state and outputs go to reset values immediately, and the in-flight operation is discarded.
- Reset values: gnt=0, in_ready=0, trp_en=0, trp_a=0, trp_mode=0, res_valid=0, res_data=0, res_id=0, res_err=0.

## Timing
- Grant: req seen in cycle t (IDLE, unit idle) -> gnt and FEED at t+1.
- Beat accepted at cycle t -> trp_en/trp_a at t+1.
- Minimum grant-to-result cost is NUM_ELEMS feed cycles, plus unit latency, plus 1 capture cycle. res_valid rises the cycle after trp_valid is sampled in WAIT.
- Back-to-back: HOLD handshake at t -> IDLE at t+1 -> next gnt at t+2.
- Only one operation is in flight. No queuing of results.

## Configuration
- TRP_CTRL_TIMEOUT_EN defined: WAIT runs a counter cleared on WAIT entry.
  - If TIMEOUT_CYCLES cycles elapse without trp_valid, go HOLD with res_data=0 and res_err=1.
  - A trp_valid in the same cycle as expiry wins, with res_err=0.
- Not defined: no counter. WAIT waits indefinitely, and res_err is tied 0.

## Test plan
- Single request: req=01, mode0=2, beats 1..8 with in_valid constant -> trp_mode=2; trp_en pulses 8 cycles carrying 1..8; unit returns 36 -> res_valid, res_data=36, res_id=0, res_err=0.
- Tie: req=11 from reset -> gnt=01 first; after its handshake, gnt=10 with req still 11; then alternates 01 and 10.
- Back-pressure: in_valid toggling 1,0,1,… -> exactly 8 trp_en pulses; in_ready drops after the 8th beat. res_ready held 0 for 5 cycles -> res_data stable, gnt held, no new grant.
- Busy gating: trp_busy=1 with req=01 -> gnt stays 0; trp_busy falls at t -> gnt=01 at t+1.
- Reset in FEED after 3 beats: resetn low -> all outputs 0 asynchronously. After release with req=10 -> gnt=10 and a full 8-beat sequence.
- Timeout (macro on, TIMEOUT_CYCLES=16): no trp_valid after feed -> res_valid 17 cycles after WAIT entry with res_err=1, res_data=0. Macro off: res_valid stays 0.
